mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle main control FSM that sequences the instruction fetch unit, register file, ALU, data memory and CP0. It decodes op/func/rs from the fetch unit and issues per-state strobes: PC write, next-PC select, register/memory writes, and the interrupt entry/exit controls. Interrupts are sampled only at instruction boundaries.

Parameters:
INT_EN, 1, 1 = interrupt entry logic present; 0 = irq ignored and INT state unreachable
HANDLER_CYC, 1, number of cycles spent in S_INT (1..3) before returning to S_FETCH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  6  instruction[31:26]
func  in  6  instruction[5:0]
rs  in  5  instruction[25:21]; selects COP0 sub-op
zero  in  1  ALU zero flag, valid in S_BRANCH
irq  in  1  level interrupt request
ie  in  1  CP0 SR.IE
exl  in  1  CP0 SR.EXL
PCWr  out  1  PC write enable
IRWr  out  1  instruction register write
npc_sel  out  1  1 = branch target
jump  out  2  00 seq/branch, 01 j/jal, 10 jr, 11 epc
irq_take  out  1  next-PC = handler address
RegWr  out  1  register file write
RegDst  out  2  00 rt, 01 rd, 10 $31
MemToReg  out  2  00 ALU, 01 mem, 10 jal_reg, 11 CP0
ALUSrc  out  1  1 = extended immediate
ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui
ExtOp  out  1  1 = sign extend
MemWr  out  1  data memory write
CP0Wr  out  1  mtc0 write
EPCWr  out  1  latch PC into EPC
EXLSet  out  1  set SR.EXL
EXLClr  out  1  clear SR.EXL

Behaviour:
- Moore outputs decoded from state plus registered decode class; every output is 0 while reset is high and in the state after reset; the state after reset is S_FETCH.
- States: S_FETCH, S_DECODE, S_EXE, S_MEMADR, S_MEMRD, S_MEMWR, S_WB, S_BRANCH, S_JUMP, S_C0, S_ERET, S_INT.
- S_FETCH: IRWr=1, PCWr=1, jump=00, npc_sel=0 (PC+4); next state S_DECODE.
- S_DECODE: no strobes.
  - R-type addu/subu -> S_EXE.
  - ori/lui -> S_EXE.
  - lw/sw -> S_MEMADR.
  - beq -> S_BRANCH.
  - j/jal/jr -> S_JUMP.
  - COP0 rs=00000 (mfc0) or rs=00100 (mtc0) -> S_C0.
  - COP0 rs=10000 with func=011000 (eret) -> S_ERET.
  - Any other encoding is a NOP and ends the instruction.
- S_EXE: ALUOp by instruction; ALUSrc=1 and ExtOp=0 for ori/lui; next state S_WB.
- S_MEMADR: ALUOp=add, ALUSrc=1, ExtOp=1; lw -> S_MEMRD, sw -> S_MEMWR.
- S_MEMRD: next state S_WB. S_MEMWR: MemWr=1; ends the instruction.
- S_WB: RegWr=1. R-type: RegDst=01, MemToReg=00. ori/lui: RegDst=00, MemToReg=00. lw: RegDst=00, MemToReg=01. Ends the instruction.
- S_BRANCH: ALUOp=sub, npc_sel=1, PCWr=zero; ends the instruction.
- S_JUMP: PCWr=1; jump=01 for j/jal, 10 for jr. jal also asserts RegWr=1, RegDst=10, MemToReg=10 in the same cycle. Ends the instruction.
- S_C0: mfc0: RegWr=1, RegDst=00, MemToReg=11. mtc0: CP0Wr=1. Ends the instruction.
- S_ERET: PCWr=1, jump=11, EXLClr=1. Ends the instruction; interrupt sampling is suppressed in this cycle.
- Instruction end: next state is S_INT if INT_EN && irq && ie && !exl, otherwise S_FETCH. irq is sampled in the ending cycle only.
- S_INT, first cycle: EPCWr=1, EXLSet=1, PCWr=1, irq_take=1. Any remaining HANDLER_CYC-1 cycles assert no strobes. Then S_FETCH.
- Latency per instruction (excluding S_INT):
  - 5 cycles: lw.
  - 4 cycles: R-type, ori, lui, sw.
  - 3 cycles: beq, j, jal, jr, mfc0, mtc0, eret, NOP.
- reset asserted in any state returns the FSM to S_FETCH immediately with all outputs 0; no partial write completes.
- At most one of PCWr-source {seq, branch, jump, irq_take} is active per cycle. MemWr and RegWr are never both 1.

Decomposition:
- Package mc_pkg holds:
  - state encoding (4-bit localparams);
  - opcode/func/COP0-rs constants;
  - ALUOp, RegDst, MemToReg and jump codes.
- One sub-module, mc_decode: combinational op/func/rs -> instruction-class one-hot. mc_ctrl registers the class in S_DECODE and holds the FSM and output logic.

Test Plan:
- Reset: assert reset mid-S_MEMRD -> state S_FETCH, all outputs 0, asynchronously. Release -> first cycle IRWr=1, PCWr=1.
- addu (op 000000, func 100001) -> cycle sequence FETCH, DECODE, EXE, WB; RegWr=1 with RegDst=01 only in cycle 4.
- lw (op 100011) -> 5 cycles with MemToReg=01 at WB. sw (op 101011) -> MemWr=1 exactly in cycle 4, RegWr never asserted.
- beq (op 000100): zero=1 -> PCWr=1, npc_sel=1 in cycle 3. zero=0 -> PCWr=0 in cycle 3.
- jal (op 000011) -> cycle 3 shows PCWr=1, jump=01, RegWr=1, RegDst=10, MemToReg=10.
- irq=1, ie=1, exl=0 during ori:
  - S_INT follows WB with EPCWr=1, EXLSet=1, irq_take=1.
  - With exl=1 the next state is S_FETCH instead.
  - eret -> jump=11, EXLClr=1, and the next state is S_FETCH even with irq=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle main control FSM and its instruction decoder.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXE    = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_WB     = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_JUMP   = 4'd8;
  localparam logic [3:0] S_C0     = 4'd9;
  localparam logic [3:0] S_ERET   = 4'd10;
  localparam logic [3:0] S_INT    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_COP0  = 6'b010000;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ERET  = 6'b011000;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;
  localparam logic [4:0] RS_CO    = 5'b10000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_R31  = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_JAL  = 2'b10;
  localparam logic [1:0] M2R_CP0  = 2'b11;

  localparam logic [1:0] JMP_SEQ  = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;
  localparam logic [1:0] JMP_EPC  = 2'b11;

  localparam int CLS_W  = 14;
  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_ORI  = 2;
  localparam int C_LUI  = 3;
  localparam int C_LW   = 4;
  localparam int C_SW   = 5;
  localparam int C_BEQ  = 6;
  localparam int C_J    = 7;
  localparam int C_JAL  = 8;
  localparam int C_JR   = 9;
  localparam int C_MFC0 = 10;
  localparam int C_MTC0 = 11;
  localparam int C_ERET = 12;
  localparam int C_NOP  = 13;

  typedef logic [CLS_W-1:0] cls_t;

  // br marks S_BRANCH: PCWr there follows the live ALU zero flag.
  typedef struct packed {
    logic       pcwr;
    logic       br;
    logic       irwr;
    logic       npc_sel;
    logic [1:0] jump;
    logic       irq_take;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrc;
    logic [2:0] aluop;
    logic       extop;
    logic       memwr;
    logic       cp0wr;
    logic       epcwr;
    logic       exlset;
    logic       exlclr;
  } ctl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func/rs decode into a one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic [4:0] rs_i,
  output cls_t       cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADDU: cls_o[C_ADDU] = 1'b1;
          FN_SUBU: cls_o[C_SUBU] = 1'b1;
          FN_JR:   cls_o[C_JR]   = 1'b1;
          default: cls_o[C_NOP]  = 1'b1;
        endcase
      end
      OP_ORI:  cls_o[C_ORI] = 1'b1;
      OP_LUI:  cls_o[C_LUI] = 1'b1;
      OP_LW:   cls_o[C_LW]  = 1'b1;
      OP_SW:   cls_o[C_SW]  = 1'b1;
      OP_BEQ:  cls_o[C_BEQ] = 1'b1;
      OP_J:    cls_o[C_J]   = 1'b1;
      OP_JAL:  cls_o[C_JAL] = 1'b1;
      OP_COP0: begin
        if (rs_i == RS_MFC0)                          cls_o[C_MFC0] = 1'b1;
        else if (rs_i == RS_MTC0)                     cls_o[C_MTC0] = 1'b1;
        else if (rs_i == RS_CO && func_i == FN_ERET)  cls_o[C_ERET] = 1'b1;
        else                                          cls_o[C_NOP]  = 1'b1;
      end
      default: cls_o[C_NOP] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM; outputs are registered from the state being entered.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter bit INT_EN      = 1'b1,
  parameter int HANDLER_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rs,
  input  logic       zero,
  input  logic       irq,
  input  logic       ie,
  input  logic       exl,
  output logic       PCWr,
  output logic       IRWr,
  output logic       npc_sel,
  output logic [1:0] jump,
  output logic       irq_take,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic       ExtOp,
  output logic       MemWr,
  output logic       CP0Wr,
  output logic       EPCWr,
  output logic       EXLSet,
  output logic       EXLClr
);

  logic [3:0] state_q, state_d;
  cls_t       cls_q, cls_d, cls_dec;
  logic [1:0] cnt_q, cnt_d;
  logic       fresh_q, take_int, int_first;
  ctl_t       ctl_q;

  mc_decode u_decode (.op_i(op), .func_i(func), .rs_i(rs), .cls_o(cls_dec));

  function automatic ctl_t ctl_of(input logic [3:0] st, input cls_t cls, input logic first);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH: begin c.irwr = 1'b1; c.pcwr = 1'b1; end
      S_EXE: begin
        if (cls[C_SUBU])     c.aluop = ALU_SUB;
        else if (cls[C_ORI]) c.aluop = ALU_OR;
        else if (cls[C_LUI]) c.aluop = ALU_LUI;
        else                 c.aluop = ALU_ADD;
        c.alusrc = cls[C_ORI] | cls[C_LUI];
      end
      S_MEMADR: begin c.aluop = ALU_ADD; c.alusrc = 1'b1; c.extop = 1'b1; end
      S_MEMWR:  c.memwr = 1'b1;
      S_WB: begin
        c.regwr    = 1'b1;
        c.regdst   = (cls[C_ADDU] | cls[C_SUBU]) ? DST_RD : DST_RT;
        c.memtoreg = cls[C_LW] ? M2R_MEM : M2R_ALU;
      end
      S_BRANCH: begin c.aluop = ALU_SUB; c.npc_sel = 1'b1; c.br = 1'b1; end
      S_JUMP: begin
        c.pcwr = 1'b1;
        c.jump = cls[C_JR] ? JMP_JR : JMP_J;
        if (cls[C_JAL]) begin c.regwr = 1'b1; c.regdst = DST_R31; c.memtoreg = M2R_JAL; end
      end
      S_C0: begin
        if (cls[C_MFC0]) begin c.regwr = 1'b1; c.regdst = DST_RT; c.memtoreg = M2R_CP0; end
        c.cp0wr = cls[C_MTC0];
      end
      S_ERET: begin c.pcwr = 1'b1; c.jump = JMP_EPC; c.exlclr = 1'b1; end
      S_INT: if (first) begin c.epcwr = 1'b1; c.exlset = 1'b1; c.pcwr = 1'b1; c.irq_take = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Unrecognised encodings take a strobe-free pass through S_C0 so they still last three cycles.
  always_comb begin
    take_int = INT_EN && irq && ie && !exl;
    state_d  = state_q;
    cls_d    = cls_q;
    cnt_d    = cnt_q;
    if (fresh_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          cls_d = cls_dec;
          if (cls_dec[C_ADDU] | cls_dec[C_SUBU] | cls_dec[C_ORI] | cls_dec[C_LUI]) state_d = S_EXE;
          else if (cls_dec[C_LW] | cls_dec[C_SW])                                 state_d = S_MEMADR;
          else if (cls_dec[C_BEQ])                                                state_d = S_BRANCH;
          else if (cls_dec[C_J] | cls_dec[C_JAL] | cls_dec[C_JR])                 state_d = S_JUMP;
          else if (cls_dec[C_ERET])                                               state_d = S_ERET;
          else if (cls_dec[C_MFC0] | cls_dec[C_MTC0] | cls_dec[C_NOP])            state_d = S_C0;
          else                                                                    state_d = S_FETCH;
        end
        S_EXE:    state_d = S_WB;
        S_MEMADR: state_d = cls_q[C_LW] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_d = S_WB;
        S_MEMWR, S_WB, S_BRANCH, S_JUMP, S_C0: begin
          state_d = take_int ? S_INT : S_FETCH;
          cnt_d   = '0;
        end
        S_ERET:   state_d = S_FETCH;
        S_INT: begin
          if (cnt_q == 2'(HANDLER_CYC - 1)) state_d = S_FETCH;
          cnt_d = cnt_q + 2'd1;
        end
        default:  state_d = S_FETCH;
      endcase
    end
    int_first = (state_d == S_INT) && (cnt_d == 2'd0);
  end

  // fresh_q spends the first edge after reset loading the S_FETCH strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b1;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      fresh_q <= 1'b0;
      ctl_q   <= ctl_of(state_d, cls_d, int_first);
    end
  end

  assign PCWr     = ctl_q.pcwr | (ctl_q.br & zero);
  assign IRWr     = ctl_q.irwr;
  assign npc_sel  = ctl_q.npc_sel;
  assign jump     = ctl_q.jump;
  assign irq_take = ctl_q.irq_take;
  assign RegWr    = ctl_q.regwr;
  assign RegDst   = ctl_q.regdst;
  assign MemToReg = ctl_q.memtoreg;
  assign ALUSrc   = ctl_q.alusrc;
  assign ALUOp    = ctl_q.aluop;
  assign ExtOp    = ctl_q.extop;
  assign MemWr    = ctl_q.memwr;
  assign CP0Wr    = ctl_q.cp0wr;
  assign EPCWr    = ctl_q.epcwr;
  assign EXLSet   = ctl_q.exlset;
  assign EXLClr   = ctl_q.exlclr;

endmodule
